// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing and index helpers for the register file / scoreboard slice.
package regfile_scoreboard_pkg;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]  reg_vec_t;

  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_decoder.sv
// 5-to-32 one-hot decoder with a global enable; row 0 is never selected.
module regfile_scoreboard_decoder
  import regfile_scoreboard_pkg::*;
(
  input  logic     en_i,
  input  reg_idx_t idx_i,
  output reg_vec_t onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      onehot_o[i] = en_i && (idx_i == reg_idx_t'(i));
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32-entry register file with two combinational read ports, one write port and a
// per-register busy scoreboard (reserve at decode, release at writeback).
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ctrl_writeEnable,
  input  logic [4:0]        ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic              ctrl_reserve,
  input  logic [4:0]        ctrl_reserveReg,
  input  logic [4:0]        ctrl_readRegA,
  input  logic [4:0]        ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  output logic              busy_A,
  output logic              busy_B,
  output logic [31:0]       busy_vec
);

  localparam bit Bypass = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  reg_vec_t          busy_q, busy_d;
  reg_vec_t          wr_sel, rsv_sel;

  regfile_scoreboard_decoder u_wr_dec (
    .en_i     (ctrl_writeEnable),
    .idx_i    (ctrl_writeReg),
    .onehot_o (wr_sel)
  );

  regfile_scoreboard_decoder u_rsv_dec (
    .en_i     (ctrl_reserve),
    .idx_i    (ctrl_reserveReg),
    .onehot_o (rsv_sel)
  );

  // Set is applied after clear so a new producer supersedes a same-cycle release.
  always_comb begin
    busy_d = (busy_q & ~wr_sel) | rsv_sel;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          regs_q[i] <= data_writeReg;
        end
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    data_readRegA = regs_q[ctrl_readRegA];
    if (is_zero_reg(ctrl_readRegA)) begin
      data_readRegA = '0;
    end else if (Bypass && wr_sel[ctrl_readRegA]) begin
      data_readRegA = data_writeReg;
    end
  end

  always_comb begin
    data_readRegB = regs_q[ctrl_readRegB];
    if (is_zero_reg(ctrl_readRegB)) begin
      data_readRegB = '0;
    end else if (Bypass && wr_sel[ctrl_readRegB]) begin
      data_readRegB = data_writeReg;
    end
  end

  // Busy reflects the registered scoreboard; a same-cycle release is not forwarded.
  assign busy_A   = busy_q[ctrl_readRegA];
  assign busy_B   = busy_q[ctrl_readRegB];
  assign busy_vec = busy_q;

  r0_never_busy: assert property (@(posedge clock) disable iff (!reset_n) busy_q[0] == 1'b0);
  r0_reads_zero: assert property (@(posedge clock)
    is_zero_reg(ctrl_readRegA) |-> data_readRegA == '0);

endmodule
